i2s_dac_transmitter: RTL

- Master-mode I2S transmitter that feeds the audio codec DAC.
- Accepts stereo PCM sample pairs through a valid/ready handshake and buffers one pair.
- Generates BCLK and DACLRCK from its clock and serialises each pair MSB-first on DACDAT.
- Playback-side counterpart of the ADC capture path, running from the audio master clock (AUD_XCK, 12.288 MHz).

---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_clock_gen.sv | 53 +++++
 rtl/i2s_dac_transmitter.sv | 107 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo sample type used by playback and capture.
package audio_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_BITS  = 32;
    localparam int DEF_CLK_DIV    = 2;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] left;
        logic [DEF_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S master timing: divides clk into BCLK, walks the frame bit counter and drives LRCK.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    localparam int FRAME_BITS = 2 * SLOT_BITS,
    localparam int CNT_W      = $clog2(FRAME_BITS),
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             bclk,
    output logic             lrck,
    output logic             fall_evt,
    output logic             frame_wrap,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;
    logic [CNT_W-1:0] bit_nxt;

    assign tc         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_evt   = tc && bclk;
    assign frame_wrap = fall_evt && (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign bit_nxt    = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;

    // Half-period divider; BCLK toggles at each terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Bit position and channel select advance together on the BCLK falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= CNT_W'(FRAME_BITS - 1);
            lrck    <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt <= bit_nxt;
            lrck    <= (bit_nxt >= CNT_W'(SLOT_BITS));
        end
    end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// I2S master transmitter: one-pair holding buffer, active pair register and serial data mux.
module i2s_dac_transmitter
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_BITS  = DEF_SLOT_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    pair_t            buf_pair, act_pair;
    logic             buf_full;
    logic             accept;
    logic             fall_evt, frame_wrap;
    logic [CNT_W-1:0] bit_cnt, bit_nxt, slot_pos;
    logic             right_slot;
    logic [DATA_WIDTH-1:0] sample;
    logic [IDX_W-1:0] idx;
    logic             dat_nxt;

    i2s_clock_gen #(
        .SLOT_BITS (SLOT_BITS),
        .CLK_DIV   (CLK_DIV)
    ) u_clk (
        .clk        (clk),
        .reset      (reset),
        .bclk       (AUD_BCLK),
        .lrck       (AUD_DACLRCK),
        .fall_evt   (fall_evt),
        .frame_wrap (frame_wrap),
        .bit_cnt    (bit_cnt)
    );

    assign in_ready = ~buf_full;
    assign accept   = in_valid && in_ready;

    // Only meaningful on a falling-edge event, where a wrap forces the slot back to 0.
    assign bit_nxt    = frame_wrap ? '0 : bit_cnt + 1'b1;
    assign right_slot = (bit_nxt >= CNT_W'(SLOT_BITS));
    assign slot_pos   = right_slot ? bit_nxt - CNT_W'(SLOT_BITS) : bit_nxt;
    assign sample     = right_slot ? act_pair.right : act_pair.left;

    // Slot position 0 is the I2S one-bit delay; positions past the sample pad with zeros.
    always_comb begin
        dat_nxt = 1'b0;
        idx     = '0;
        if (slot_pos != '0 && int'(slot_pos) <= DATA_WIDTH) begin
            idx     = IDX_W'(DATA_WIDTH - int'(slot_pos));
            dat_nxt = sample[idx];
        end
    end

    // Holding buffer and active pair; a load sees the buffer as it was before any same-edge accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_pair <= '0;
            act_pair <= '0;
        end else begin
            if (frame_wrap) begin
                if (buf_full) begin
                    act_pair <= buf_pair;
                    buf_full <= 1'b0;
                end else begin
                    act_pair <= '0;
                end
            end
            if (accept) begin
                buf_pair <= '{left: in_left, right: in_right};
                buf_full <= 1'b1;
            end
        end
    end

    // Serial data changes with the BCLK fall; status pulses mark each frame load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (fall_evt) AUD_DACDAT <= dat_nxt;
            frame_start <= frame_wrap;
            underrun    <= frame_wrap && !buf_full;
        end
    end

endmodule
